// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
interface i2s_tx_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_left;
  logic [DATA_WIDTH-1:0] s_right;

  // Source side drives the pair, transmitter answers with ready.
  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S / left-justified serial audio transmitter: one frame counter derives
// SCLK and LRCLK, a one-deep buffer decouples the source from frame loads.
module i2s_tx #(
  parameter int unsigned SCLK_DIV   = 8,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned I2S_MODE   = 1
) (
  input  logic     clk_i2s,
  input  logic     reset_n,
  i2s_tx_if.slave  s,
  output logic     tx_mclk,
  output logic     tx_sclk,
  output logic     tx_lrclk,
  output logic     tx_data,
  output logic     underrun
);

  localparam int unsigned FRAME_CYC  = 2 * SLOT_WIDTH * SCLK_DIV;
  localparam int unsigned CTR_W      = $clog2(FRAME_CYC);
  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned HALF_CYC   = SCLK_DIV / 2;
  localparam int unsigned LR_CYC     = SLOT_WIDTH * SCLK_DIV;
  localparam int unsigned PAD        = SLOT_WIDTH - DATA_WIDTH;

  logic [CTR_W-1:0]      ctr;
  logic [CTR_W-1:0]      ctr_nxt;
  logic                  started;
  logic                  load;
  logic                  bit_edge;
  logic                  sclk_nxt;
  logic                  lrclk_nxt;
  logic                  accept;
  logic                  buf_full;
  logic                  buf_full_nxt;
  logic [DATA_WIDTH-1:0] buf_l;
  logic [DATA_WIDTH-1:0] buf_r;
  logic [FRAME_BITS-1:0] sh;
  logic [FRAME_BITS-1:0] frame_new;
  logic [FRAME_BITS-1:0] sh_src;
  logic                  lj_bit;
  logic                  dly;

  // MCLK is the master clock passed straight through to the DAC.
  assign tx_mclk = clk_i2s;

  // Next phase, frame load decision, next clock levels and next LJ bit.
  always_comb begin
    ctr_nxt = '0;
    if (started && (32'(ctr) != FRAME_CYC - 1)) begin
      ctr_nxt = ctr + CTR_W'(1);
    end
    load      = (ctr_nxt == '0);
    bit_edge  = ((32'(ctr_nxt) % SCLK_DIV) == 32'd0);
    sclk_nxt  = ((32'(ctr_nxt) % SCLK_DIV) >= HALF_CYC);
    lrclk_nxt = (32'(ctr_nxt) >= LR_CYC);

    accept       = s.s_valid & ~buf_full;
    buf_full_nxt = accept | (buf_full & ~load);

    frame_new = '0;
    if (buf_full) begin
      frame_new = {SLOT_WIDTH'(buf_l) << PAD, SLOT_WIDTH'(buf_r) << PAD};
    end
    sh_src = load ? frame_new : sh;
    lj_bit = sh_src[FRAME_BITS-1];
  end

  // Phase counter, clocks, holding buffer and serialiser state.
  always_ff @(posedge clk_i2s or negedge reset_n) begin
    if (!reset_n) begin
      started   <= 1'b0;
      ctr       <= '0;
      tx_sclk   <= 1'b0;
      tx_lrclk  <= 1'b0;
      tx_data   <= 1'b0;
      underrun  <= 1'b0;
      buf_full  <= 1'b0;
      s.s_ready <= 1'b1;
      buf_l     <= '0;
      buf_r     <= '0;
      sh        <= '0;
      dly       <= 1'b0;
    end else begin
      started   <= 1'b1;
      ctr       <= ctr_nxt;
      tx_sclk   <= sclk_nxt;
      tx_lrclk  <= lrclk_nxt;
      underrun  <= load & ~buf_full;
      buf_full  <= buf_full_nxt;
      s.s_ready <= ~buf_full_nxt;
      if (accept) begin
        buf_l <= s.s_left;
        buf_r <= s.s_right;
      end
      // Data moves only on SCLK falling edges; I2S lags LJ by one bit.
      if (bit_edge) begin
        sh      <= sh_src << 1;
        dly     <= lj_bit;
        tx_data <= (I2S_MODE != 0) ? dly : lj_bit;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: an I2S 16/16 instance and a left-justified
// 24-in-32 instance, checked frame by frame against queued expectations.
module tb_i2s_tx;

  localparam int DIV = 8;

  typedef struct {
    int          frame;
    logic [63:0] lj;
  } exp_t;

  logic clk_i2s = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_i2s = ~clk_i2s;

  i2s_tx_if #(.DATA_WIDTH(16)) bus0 ();
  i2s_tx_if #(.DATA_WIDTH(24)) bus1 ();

  logic [1:0] mclk_w, sclk_w, lr_w, data_w, ur_w;

  i2s_tx #(.SCLK_DIV(8), .SLOT_WIDTH(16), .DATA_WIDTH(16), .I2S_MODE(1)) u_dut0 (
    .clk_i2s  (clk_i2s),
    .reset_n  (reset_n),
    .s        (bus0),
    .tx_mclk  (mclk_w[0]),
    .tx_sclk  (sclk_w[0]),
    .tx_lrclk (lr_w[0]),
    .tx_data  (data_w[0]),
    .underrun (ur_w[0])
  );

  i2s_tx #(.SCLK_DIV(8), .SLOT_WIDTH(32), .DATA_WIDTH(24), .I2S_MODE(0)) u_dut1 (
    .clk_i2s  (clk_i2s),
    .reset_n  (reset_n),
    .s        (bus1),
    .tx_mclk  (mclk_w[1]),
    .tx_sclk  (sclk_w[1]),
    .tx_lrclk (lr_w[1]),
    .tx_data  (data_w[1]),
    .underrun (ur_w[1])
  );

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[2][$];
  int   phi_t[2];
  int   frame_t[2];
  bit   started_t[2];

  function automatic int frame_len(input int i);
    return (i == 0) ? 256 : 512;
  endfunction

  function automatic int fbits(input int i);
    return (i == 0) ? 32 : 64;
  endfunction

  function automatic logic rdy(input int i);
    return (i == 0) ? bus0.s_ready : bus1.s_ready;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [23:0] l, input logic [23:0] r);
    if (i == 0) begin
      bus0.s_valid = v;
      bus0.s_left  = l[15:0];
      bus0.s_right = r[15:0];
    end else begin
      bus1.s_valid = v;
      bus1.s_left  = l;
      bus1.s_right = r;
    end
  endtask

  // Offer a pair, wait for ready, and queue the frame it must play in.
  task automatic send(input int i, input logic [23:0] l, input logic [23:0] r, output int acc_phi);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_i2s);
    drive(i, 1'b1, l, r);
    while (rdy(i) !== 1'b1 && n < 3000) begin
      @(negedge clk_i2s);
      n++;
    end
    if (n >= 3000) begin
      check($sformatf("accept_timeout_dut%0d", i), 64'd1, 64'd0);
      drive(i, 1'b0, 24'h0, 24'h0);
      acc_phi = -1;
      return;
    end
    acc_phi = phi_t[i];
    @(posedge clk_i2s);
    #1;
    drive(i, 1'b0, 24'h0, 24'h0);
    e.frame = frame_t[i] + 1;
    e.lj    = (i == 0) ? {32'h0, l[15:0], r[15:0]} : {l, 8'h00, r, 8'h00};
    exp_q[i].push_back(e);
  endtask

  // Reference phase/frame tracker; phase 0 is the first edge after release.
  always @(posedge clk_i2s or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        started_t[i] <= 1'b0;
        phi_t[i]     <= 0;
        frame_t[i]   <= 0;
      end else if (!started_t[i]) begin
        started_t[i] <= 1'b1;
        phi_t[i]     <= 0;
        frame_t[i]   <= 0;
      end else if (phi_t[i] == frame_len(i) - 1) begin
        phi_t[i]     <= 0;
        frame_t[i]   <= frame_t[i] + 1;
      end else begin
        phi_t[i]     <= phi_t[i] + 1;
      end
    end
  end

  // Monitor: per-cycle clock/pulse checks, bit capture on SCLK high, frame compare.
  logic [63:0] cap[2];
  logic        ur0[2];
  logic        prev_last[2];
  logic        last_d[2];

  initial begin
    int          phi, b, flen;
    logic [63:0] exp_lj, exp_tx;
    logic        exp_ur;
    exp_t        e;
    forever begin
      @(negedge clk_i2s);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n || !started_t[i]) begin
          prev_last[i] = 1'b0;
          cap[i]       = '0;
          last_d[i]    = 1'b0;
          ur0[i]       = 1'b0;
        end else begin
          phi  = phi_t[i];
          flen = frame_len(i);
          b    = phi / DIV;
          check($sformatf("clocks_dut%0d_phi%0d", i, phi),
                {61'h0, mclk_w[i], sclk_w[i], lr_w[i]},
                {61'h0, 1'b0, ((phi % DIV) >= DIV / 2), (phi >= flen / 2)});
          if (phi != 0) check($sformatf("underrun_idle_dut%0d", i), 64'(ur_w[i]), 64'd0);
          else ur0[i] = ur_w[i];
          if ((phi % DIV) != 0) check($sformatf("data_stable_dut%0d", i), 64'(data_w[i]), 64'(last_d[i]));
          last_d[i] = data_w[i];
          if ((phi % DIV) == DIV / 2) cap[i][fbits(i) - 1 - b] = data_w[i];
          if (phi == flen - 1) begin
            exp_lj = '0;
            exp_ur = 1'b1;
            if (exp_q[i].size() > 0 && exp_q[i][0].frame == frame_t[i]) begin
              e      = exp_q[i].pop_front();
              exp_lj = e.lj;
              exp_ur = 1'b0;
            end
            exp_tx = (i == 0) ? {32'h0, prev_last[i], exp_lj[31:1]} : exp_lj;
            check($sformatf("frame%0d_data_dut%0d", frame_t[i], i), cap[i], exp_tx);
            check($sformatf("frame%0d_underrun_dut%0d", frame_t[i], i), 64'(ur0[i]), 64'(exp_ur));
            prev_last[i] = exp_lj[0];
            cap[i]       = '0;
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int a0, a1, a2, a3, n;
    drive(0, 1'b0, 24'h0, 24'h0);
    drive(1, 1'b0, 24'h0, 24'h0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk_i2s);
    #1;
    check("reset_outputs", {54'h0, sclk_w, lr_w, data_w, ur_w, rdy(0), rdy(1)}, 64'h3);
    @(negedge clk_i2s);
    reset_n = 1'b1;
    repeat (300) @(negedge clk_i2s);

    // Back-to-back pairs on the I2S instance, one padded pair on the LJ instance.
    fork
      begin
        send(0, 24'h00A5F0, 24'h000F3C, a0);
        @(negedge clk_i2s);
        check("ready_low_after_accept", 64'(rdy(0)), 64'd0);
        send(0, 24'h001234, 24'h008001, a1);
        check("second_accept_phase", 64'(a1), 64'd0);
        @(negedge clk_i2s);
        check("ready_low_after_second", 64'(rdy(0)), 64'd0);
      end
      begin
        send(1, 24'h800001, 24'h7FFFFE, a2);
      end
    join
    repeat (1300) @(negedge clk_i2s);

    // Reset in the middle of a frame with the buffer holding a pair.
    n = 0;
    while (phi_t[0] != 20 && n < 1000) begin @(negedge clk_i2s); n++; end
    send(0, 24'h00C3C3, 24'h003C3C, a3);
    n = 0;
    while (phi_t[0] != 100 && n < 1000) begin @(negedge clk_i2s); n++; end
    check("phase100_reached", 64'(phi_t[0]), 64'd100);
    check("ready_low_buffer_full", 64'(rdy(0)), 64'd0);
    reset_n = 1'b0;
    #1;
    check("reset_mid_frame_outputs", {54'h0, sclk_w, lr_w, data_w, ur_w, rdy(0), rdy(1)}, 64'h3);
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (4) @(negedge clk_i2s);
    reset_n = 1'b1;
    @(posedge clk_i2s);
    #1;
    check("underrun_after_reset_dut0", 64'(ur_w[0]), 64'd1);
    check("underrun_after_reset_dut1", 64'(ur_w[1]), 64'd1);
    repeat (600) @(negedge clk_i2s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parametrised I2S / left-justified serial audio transmitter driven from `clk_i2s`. It generates MCLK, SCLK and LRCLK from a single frame counter. It accepts one stereo sample pair per frame over a valid/ready handshake, with a one-deep holding buffer, and serialises the pair MSB-first onto `tx_data`. It drives the external DAC directly; sample rate = f(clk_i2s) / (2·SLOT_WIDTH·SCLK_DIV).

## Interface
- `SCLK_DIV`, 8: clk_i2s cycles per SCLK period; even, ≥2.
- `SLOT_WIDTH`, 16: SCLK periods per channel slot; frame = 2·SLOT_WIDTH bits.
- `DATA_WIDTH`, 16: sample width; 1 ≤ DATA_WIDTH ≤ SLOT_WIDTH.
- `I2S_MODE`, 1: 1 = Philips I2S (data one SCLK after LRCLK edge); 0 = left-justified.
- `clk_i2s  in  1  master clock (12.288 MHz nominal)`
- `reset_n  in  1  asynchronous, active-low reset`
- `s_valid  in  1  sample pair valid`
- `s_ready  out  1  block can accept a pair`
- `s_left  in  DATA_WIDTH  left sample, two's complement`
- `s_right  in  DATA_WIDTH  right sample, two's complement`
- `tx_mclk  out  1  equals clk_i2s (pass-through)`
- `tx_sclk  out  1  bit clock`
- `tx_lrclk  out  1  word select; 0 = left, 1 = right`
- `tx_data  out  1  serial data`
- `underrun  out  1  one-cycle pulse: frame started with no sample buffered`

Reset is asynchronous, active-low, on `reset_n`; the clock is `clk_i2s`.

## Operation
- Frame counter `ctr`: width $clog2(2·SLOT_WIDTH·SCLK_DIV), counts 0 … 2·SLOT_WIDTH·SCLK_DIV−1, then wraps to 0. Phase φ = ctr value in the cycle the outputs are visible.
- Derived indices: bit index b = φ / SCLK_DIV; slot position p = b mod SLOT_WIDTH.
- `tx_sclk` = 1 when (φ mod SCLK_DIV) ≥ SCLK_DIV/2, so it is low for the first half of each bit. `tx_lrclk` = 1 when b ≥ SLOT_WIDTH.
- Left-justified stream LJ(b):
  - Left slot: s_left bit DATA_WIDTH−1−p for p < DATA_WIDTH, else 0.
  - Right slot: the same rule applied to s_right.
- `tx_data`: equals LJ when I2S_MODE = 0. When I2S_MODE = 1 it is LJ delayed by exactly SCLK_DIV cycles, so the previous frame's last bit appears at b = 0.
- `tx_data` changes only when φ mod SCLK_DIV = 0 (SCLK falling edge). The DAC samples on SCLK rising edges.
- Holding buffer (one pair) and `s_ready`:
  - `s_ready` = buffer empty.
  - A transfer occurs when `s_valid` & `s_ready` on a rising edge; the buffer becomes full.
- Frame load on the edge entering φ = 0:
  - Buffer full: the pair moves into a 2·SLOT_WIDTH shift register and the buffer empties.
  - Buffer empty: zeros are loaded and `underrun` = 1 for the φ = 0 cycle.
- Simultaneous accept and load with an empty buffer: the load still sees empty (zeros, underrun pulse). The accepted pair is stored and plays in the next frame.
- A full buffer is never overwritten. Inputs are ignored while `s_ready` = 0.

## Timing
- While `reset_n` = 0:
  - Outputs: `tx_sclk` = 0, `tx_lrclk` = 0, `tx_data` = 0, `underrun` = 0, `s_ready` = 1.
  - State: `ctr` = 0, buffer empty, shift register and I2S delay bit = 0.
- `tx_mclk` is combinational from `clk_i2s`. All other outputs are registered.
- First rising edge after release: φ = 0, and frame-load rules apply, so `underrun` pulses unless a pair was accepted on that same edge (it was not; see simultaneous rule).
- Latency: a pair accepted in frame N appears in frame N+1. Its left MSB is visible at φ = 0 (LJ) or φ = SCLK_DIV (I2S).
- `s_ready` falls the cycle after an accept. It rises the cycle after the load edge (visible at φ = 0).
- Reset asserted mid-frame: all state clears immediately. The partially sent sample and the buffered pair are discarded.
- Period checks: the LRCLK period is 2·SLOT_WIDTH·SCLK_DIV cycles at 50% duty; the SCLK period is SCLK_DIV cycles at 50% duty.

## Test plan
- **Defaults, no stimulus:** `tx_sclk` period 8, `tx_lrclk` period 256, `tx_lrclk` low for φ 0–127, `tx_data` = 0, `underrun` pulse every 256 cycles at φ = 0.
- **I2S_MODE = 0, left-justified data:** accept L = 16'hA5F0, R = 16'h0F3C before frame 1. Sampling on SCLK rising edges in frame 1 yields 0xA5F0 then 0x0F3C, MSB-first, with no underrun in frame 1.
- **I2S_MODE = 1, delayed data:** same data. Frame 1 bit 0 = 0, bits 1–16 = 0xA5F0, bits 17–31 = 0x0F3C[15:1]. Frame 2 bit 0 = 0 (the right LSB of 0x0F3C).
- **Back-to-back handshake:** drive `s_valid` for two pairs. The first is accepted immediately and `s_ready` = 0 until φ = 0. The second is accepted at φ = 0 and plays a frame later. Check no loss and no duplication over 4 frames.
- **Padding:** DATA_WIDTH = 24, SLOT_WIDTH = 32, I2S_MODE = 0, L = 24'h800001. Slot bits 0–23 = 0x800001, bits 24–31 = 0, LRCLK period 512.
- **Reset mid-frame:** assert `reset_n` = 0 at φ = 100 with the buffer full. All outputs and state go to reset values immediately. After release, φ restarts at 0 with an underrun pulse.
